// File: rtl/uart_pkg.sv
// Shared constants and state types for the UART command wrapper.
//   BaudDivDefault : clocks per bit (115200 baud at 50 MHz)
//   FrameBits      : 8N1 frame length (start + 8 data + stop)
//   POS_ACK/NEG_ACK: response codes for the remote
package uart_pkg;

  localparam int unsigned BaudDivDefault = 434;
  localparam int unsigned FrameBits      = 10;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

  typedef enum logic {RxIdle, RxRecv} rx_state_e;
  typedef enum logic {TxIdle, TxSend} tx_state_e;
  typedef enum logic {StHigh, StLow}  cmd_state_e;

endpackage

// File: rtl/uart.sv
// Full-duplex 8N1 UART engine pair.
//   clk, rst_n          : clock, async active-low reset
//   RX / TX             : serial in (asynchronous) / serial out
//   rx_data, rx_rdy     : received byte, held flag set on a good stop bit
//   clr_rx_rdy          : consumer acknowledge for rx_rdy
//   trmt, tx_data       : start request and byte to send (sampled only when idle)
//   tx_done             : set at end of stop bit, cleared on an accepted trmt
module uart
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [3:0]      LastBit  = 4'(FrameBits - 1);

  // ---------------------------------------------------------------- receiver
  // Two-flop synchronizer plus a history flop for edge detection; all preset
  // to idle-high so reset never looks like a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_rdy_q, rx_rdy_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = rx_rdy_q;
    if (clr_rx_rdy) rx_rdy_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxRecv;
          rx_baud_d  = HalfLast;   // first sample lands mid start bit
          rx_bit_d   = '0;
        end
      end
      RxRecv: begin
        if (rx_baud_q == '0) begin
          rx_baud_d = BaudLast;
          rx_bit_d  = rx_bit_q + 4'd1;
          if (rx_bit_q == '0) begin
            if (rx_sync_q) begin   // start bit gone: glitch, not a frame
              rx_state_d = RxIdle;
              rx_baud_d  = '0;
              rx_bit_d   = '0;
            end
          end else if (rx_bit_q == LastBit) begin
            rx_state_d = RxIdle;
            rx_baud_d  = '0;
            rx_bit_d   = '0;
            if (rx_sync_q) rx_rdy_d = 1'b1;  // framing error drops the byte
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          end
        end else begin
          rx_baud_d = rx_baud_q - CntOne;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  assign rx_data = rx_shift_q;
  assign rx_rdy  = rx_rdy_q;

  // ------------------------------------------------------------- transmitter
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_baud_q, tx_baud_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [FrameBits-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_done_q, tx_done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (trmt) begin
          tx_state_d = TxSend;
          tx_shift_d = {1'b1, tx_data, 1'b0};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_done_d  = 1'b0;
        end
      end
      TxSend: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b1, tx_shift_q[FrameBits-1:1]};
          if (tx_bit_q == LastBit) begin
            tx_state_d = TxIdle;
            tx_bit_d   = '0;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + CntOne;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Line idles high whenever no frame is in flight, including straight out of reset.
  assign TX      = (tx_state_q == TxSend) ? tx_shift_q[0] : 1'b1;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_wrapper.sv
// Assembles two received bytes into a 16-bit command and sends response bytes.
//   clk, rst_n    : clock, async active-low reset
//   RX / TX       : serial command in / serial response out (8N1)
//   cmd, cmd_rdy  : {first byte, second byte} and its valid flag
//   clr_cmd_rdy   : consumer acknowledge (loses to a coincident set)
//   resp, trmt    : response byte and one-cycle send request
//   tx_done       : last response fully shifted out
module uart_wrapper
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rx_rdy;

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .TX        (TX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .trmt      (trmt),
    .tx_data   (resp),
    .tx_done   (tx_done)
  );

  cmd_state_e state_q, state_d;
  logic [7:0] cmd_hi_q, cmd_hi_d;
  logic [7:0] cmd_lo_q, cmd_lo_d;
  logic       cmd_rdy_q, cmd_rdy_d;

  always_comb begin
    state_d    = state_q;
    cmd_hi_d   = cmd_hi_q;
    cmd_lo_d   = cmd_lo_q;
    cmd_rdy_d  = cmd_rdy_q;
    clr_rx_rdy = 1'b0;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    // Set is evaluated after the acknowledge so a coincident set wins.
    if (rx_rdy) begin
      clr_rx_rdy = 1'b1;
      unique case (state_q)
        StHigh: begin
          cmd_hi_d  = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = StLow;
        end
        StLow: begin
          cmd_lo_d  = rx_data;
          cmd_rdy_d = 1'b1;
          state_d   = StHigh;
        end
        default: state_d = StHigh;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHigh;
      cmd_hi_q  <= '0;
      cmd_lo_q  <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_hi_q  <= cmd_hi_d;
      cmd_lo_q  <= cmd_lo_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign cmd     = {cmd_hi_q, cmd_lo_q};
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Self-checking bench for uart_wrapper: table of command/response vectors run
// full duplex, plus hand sequences for set-vs-clear priority and mid-frame reset.
module tb_uart_wrapper;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] cmd_sb[$];
  logic        tx_sb[$];

  uart_wrapper #(
    .BAUD_DIV(BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    RX = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    drive_bit(stop);
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    cmd_sb.push_back({b0, b1});
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
  endtask

  task automatic pop_cmd(input string name);
    if (cmd_sb.size() > 0) chk(name, {16'h0, cmd}, {16'h0, cmd_sb.pop_front()});
    else chk({name, " scoreboard empty"}, 32'd0, 32'd1);
  endtask

  // Bounded wait for cmd_rdy, compare cmd, then check hold and acknowledge.
  task automatic wait_cmd(input string name);
    int k = 0;
    while (cmd_rdy !== 1'b1 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, " cmd_rdy"}, {31'h0, cmd_rdy}, 32'd1);
    pop_cmd({name, " cmd"});
    repeat (3) @(posedge clk);
    #1;
    chk({name, " cmd_rdy held"}, {31'h0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    chk({name, " cmd_rdy cleared"}, {31'h0, cmd_rdy}, 32'd0);
  endtask

  // Send r and check every bit mid-cell; optionally retrigger with r2 mid-frame.
  task automatic tx_frame(input logic [7:0] r, input logic dup, input logic [7:0] r2);
    tx_sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_sb.push_back(r[i]);
    tx_sb.push_back(1'b1);
    resp = r;
    trmt = 1'b1;
    @(posedge clk);
    #1;
    trmt = 1'b0;
    resp = 8'h00;
    chk("tx_done cleared on trmt", {31'h0, tx_done}, 32'd0);
    for (int c = 0; c < 10 * BD; c++) begin
      if (dup && c == 3 * BD) begin
        resp = r2;
        trmt = 1'b1;
      end else if (trmt) begin
        trmt = 1'b0;
        resp = 8'h00;
      end
      if (c % BD == BD / 2) begin
        if (tx_sb.size() > 0) chk("tx bit", {31'h0, TX}, {31'h0, tx_sb.pop_front()});
        else chk("tx scoreboard empty", 32'd0, 32'd1);
      end
      if (c == 10 * BD - 1) chk("tx_done before end", {31'h0, tx_done}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("tx_done at 10 bit times", {31'h0, tx_done}, 32'd1);
    for (int c = 0; c < 2 * BD; c++) begin
      if (c % BD == BD / 2) chk("tx idle after frame", {31'h0, TX}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("tx_done held", {31'h0, tx_done}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] rsp;
    logic       pre_bad;
    logic       pre_glitch;
    logic       dup_trmt;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] last_cmd;

  initial begin
    vecs[0] = '{b0: 8'h2F, b1: 8'hA5, rsp: 8'hA5, pre_bad: 1'b0, pre_glitch: 1'b0, dup_trmt: 1'b0};
    vecs[1] = '{b0: 8'h40, b1: 8'h07, rsp: 8'h3C, pre_bad: 1'b1, pre_glitch: 1'b0, dup_trmt: 1'b1};
    vecs[2] = '{b0: 8'hC3, b1: 8'h3C, rsp: 8'hEE, pre_bad: 1'b0, pre_glitch: 1'b1, dup_trmt: 1'b0};
    vecs[3] = '{b0: 8'hFF, b1: 8'h00, rsp: 8'h01, pre_bad: 1'b0, pre_glitch: 1'b0, dup_trmt: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset TX", {31'h0, TX}, 32'd1);
    chk("reset cmd", {16'h0, cmd}, 32'h0);
    chk("reset cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
    chk("reset tx_done", {31'h0, tx_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * BD) @(posedge clk);
    #1;
    last_cmd = 16'h0000;

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].pre_bad) begin
        send_byte(8'h55, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("bad stop no cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
        chk("bad stop cmd held", {16'h0, cmd}, {16'h0, last_cmd});
      end
      if (vecs[v].pre_glitch) begin
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("glitch no cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
      end
      fork
        send_pair(vecs[v].b0, vecs[v].b1);
        tx_frame(vecs[v].rsp, vecs[v].dup_trmt, 8'hEE);
      join
      wait_cmd("vector");
      last_cmd = {vecs[v].b0, vecs[v].b1};
      drive_bit(1'b1);
    end

    // Acknowledge on the set cycle: set wins, next-cycle acknowledge clears.
    clr_cmd_rdy = 1'b1;
    cmd_sb.push_back(16'h5AC3);
    send_byte(8'h5A, 1'b1);
    send_head(8'hC3);
    RX = 1'b1;
    begin
      int k = 0;
      while (cmd_rdy !== 1'b1 && k < 2 * BD) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk("set wins over clr", {31'h0, cmd_rdy}, 32'd1);
    pop_cmd("set wins cmd");
    @(posedge clk);
    #1;
    chk("clr one cycle later", {31'h0, cmd_rdy}, 32'd0);
    clr_cmd_rdy = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Reset mid RX byte and mid TX frame.
    fork
      begin
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
      end
      begin
        resp = 8'hA5;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
      end
    join
    rst_n = 1'b0;
    #1;
    chk("mid reset TX", {31'h0, TX}, 32'd1);
    chk("mid reset cmd", {16'h0, cmd}, 32'h0);
    chk("mid reset cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
    chk("mid reset tx_done", {31'h0, tx_done}, 32'd0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * BD) @(posedge clk);
    #1;
    chk("post reset TX idle", {31'h0, TX}, 32'd1);
    send_pair(8'h12, 8'h34);
    wait_cmd("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 The module SHALL have parameter BAUD_DIV, default 434, meaning clocks per bit (115200 baud at 50 MHz).
REQ-002 The module SHALL have port clk, input, 1 bit: system clock, all flops on rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port RX, input, 1 bit: serial command line from remote, asynchronous to clk.
REQ-005 The module SHALL have port TX, output, 1 bit: serial response line to remote.
REQ-006 The module SHALL have port cmd, output, 16 bits: assembled command, {first byte, second byte}.
REQ-007 The module SHALL have port cmd_rdy, output, 1 bit: a complete 16-bit cmd is valid.
REQ-008 The module SHALL have port clr_cmd_rdy, input, 1 bit: consumer acknowledge that clears cmd_rdy.
REQ-009 The module SHALL have port resp, input, 8 bits: response byte to transmit.
REQ-010 The module SHALL have port trmt, input, 1 bit: one-cycle request to start sending resp.
REQ-011 The module SHALL have port tx_done, output, 1 bit: last response has fully shifted out.

Function
REQ-012 The serial format SHALL be 8N1 on both lines: start bit 0, 8 data bits LSB first, stop bit 1, idle 1.
REQ-013 RX SHALL pass through two flops, all flops preset to 1, before any use.
REQ-014 On a synchronized 1->0 edge while the receiver is idle, the receiver SHALL sample the start bit at BAUD_DIV/2 clocks and each later bit every BAUD_DIV clocks.
REQ-015 A start bit sampled as 1 SHALL abort reception and return the receiver to idle (glitch reject).
REQ-016 A byte whose stop bit samples as 0 SHALL be discarded with no byte-ready pulse.
REQ-017 The wrapper FSM SHALL have states HIGH and LOW and reset to HIGH.
REQ-018 In HIGH, a received byte SHALL be latched as cmd[15:8], cmd_rdy SHALL clear, and the FSM SHALL go to LOW.
REQ-019 In LOW, a received byte SHALL be latched as cmd[7:0], cmd_rdy SHALL set on the next clock, and the FSM SHALL go to HIGH.
REQ-020 cmd SHALL hold its value until the next byte is latched.
REQ-021 cmd_rdy SHALL stay set until clr_cmd_rdy or the next first byte; if clr_cmd_rdy coincides with the set condition, set SHALL win.
REQ-022 trmt while the transmitter is idle SHALL load resp; TX SHALL drive the start bit on the next clock; each bit SHALL last exactly BAUD_DIV clocks.
REQ-023 trmt while the transmitter is busy SHALL be ignored; resp SHALL only be sampled on an accepted trmt.
REQ-024 tx_done SHALL clear on an accepted trmt, set at the end of the stop bit, and hold until the next accepted trmt.
REQ-025 Receive and transmit SHALL operate independently and concurrently (full duplex).

Reset
REQ-026 Reset SHALL force TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, FSM=HIGH, and both serial engines idle with bit counters and baud counters at 0.
REQ-027 Reset asserted mid-byte SHALL abandon the partial byte or partial command immediately; after release the next valid start edge SHALL begin a new HIGH byte.

Structure
REQ-028 The package uart_pkg SHALL hold the BAUD_DIV default, the 8N1 frame bit count (10), and the response codes POS_ACK=8'hA5 and NEG_ACK=8'hEE.
REQ-029 One sub-module, uart (rx and tx engines with rx_data, rx_rdy, clr_rx_rdy, trmt, tx_data, tx_done), SHALL be instantiated; the HIGH/LOW FSM and cmd registers SHALL be in uart_wrapper.

Verification
REQ-030 Scenario: remote sends 8'h2F then 8'hA5, back to back -> cmd=16'h2FA5 and cmd_rdy=1 within 20*BAUD_DIV+10 clocks of the first start edge, and cmd_rdy held until clr_cmd_rdy.
REQ-031 Scenario: resp=8'hA5, trmt pulsed -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV clocks per bit, and tx_done=1 exactly 10*BAUD_DIV clocks after start.
REQ-032 Scenario: frame with stop bit forced 0 -> no byte accepted, FSM stays HIGH; next good pair 8'h40, 8'h07 -> cmd=16'h4007.
REQ-033 Scenario: clr_cmd_rdy asserted on the same cycle cmd_rdy sets -> cmd_rdy=1; clr_cmd_rdy one cycle later -> cmd_rdy=0.
REQ-034 Scenario: rst_n pulsed low after bit 4 of the first byte and during a TX frame -> TX=1 at once, cmd=0, FSM=HIGH; next pair 8'h12, 8'h34 -> cmd=16'h1234.
REQ-035 Scenario: second trmt with resp=8'hEE pulsed mid-frame -> the frame in progress completes unchanged and no second frame starts.
